// File: rtl/shift_pattern_monitor.sv
// shift_pattern_monitor
// Watches the 8-bit shift counter bus and checks that it follows the one-hot
// rotate-left sequence 0x01 -> 0x02 -> ... -> 0x80 -> 0x01.
// While the bus is locked it reports the live bit position and counts completed
// laps. A broken sequence while locked raises a sticky error and bumps a
// saturating fault counter, and the monitor then hunts for lock again.
module shift_pattern_monitor #(
    parameter int LAP_W       = 8,
    parameter int RESYNC_HITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       count_in,
    output logic [2:0]       pos,
    output logic             pos_valid,
    output logic [LAP_W-1:0] lap_count,
    output logic             lap_tick,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam logic [2:0] HITS_TARGET = 3'(RESYNC_HITS);

    mon_state_t state_q;
    logic [7:0] prev;
    logic [2:0] hits;
    logic [2:0] hits_next;
    logic       prev_legal;
    logic       is_step;
    logic       is_hold;
    logic       is_wrap;
    logic [2:0] count_pos;

    // Bit index of a one-hot value; only used when the value is known to be one-hot.
    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Classify the incoming value against the previously sampled one.
    // A zero prev (after reset) is never legal, so no step can occur on the first edge.
    assign prev_legal = (prev != 8'h00) && ((prev & (prev - 8'd1)) == 8'h00);
    assign is_step    = prev_legal && (count_in == {prev[6:0], prev[7]});
    assign is_hold    = prev_legal && (count_in == prev);
    assign is_wrap    = (prev == 8'h80) && (count_in == 8'h01);
    assign count_pos  = onehot_index(count_in);
    assign hits_next  = hits + 3'd1;

    assign state = state_q;

    // Monitor state machine; every output is registered here.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, matching real flop behaviour.
        if (reset) begin
            state_q   <= HUNT;
            prev      <= 8'h00;
            hits      <= 3'd0;
            pos       <= 3'd0;
            pos_valid <= 1'b0;
            lap_count <= '0;
            lap_tick  <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            // prev always follows the bus, including the value seen during FAULT,
            // so that value can be the first half of the next legal step.
            prev     <= count_in;
            lap_tick <= 1'b0;

            case (state_q)
                HUNT: begin
                    if (is_step) begin
                        if (hits_next == HITS_TARGET) begin
                            // Entry edge: a wrap seen here is deliberately not counted.
                            state_q   <= TRACK;
                            pos       <= count_pos;
                            pos_valid <= 1'b1;
                            hits      <= 3'd0;
                        end else begin
                            hits <= hits_next;
                        end
                    end else begin
                        hits <= 3'd0;
                    end
                end

                TRACK: begin
                    if (is_step) begin
                        pos <= count_pos;
                        if (is_wrap) begin
                            lap_count <= lap_count + LAP_W'(1);
                            lap_tick  <= 1'b1;
                        end
                    end else if (!is_hold) begin
                        // pos keeps its last good value; only pos_valid drops.
                        state_q   <= FAULT;
                        pos_valid <= 1'b0;
                        err       <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end

                FAULT: begin
                    state_q <= HUNT;
                    hits    <= 3'd0;
                end

                default: begin
                    state_q <= HUNT;
                    hits    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_pattern_monitor.sv
// Testbench for shift_pattern_monitor: directed scenarios plus randomized
// traffic, checked against a behavioural model of the monitor's rules.
module tb_shift_pattern_monitor;

    localparam int LAP_W       = 8;
    localparam int RESYNC_HITS = 2;
    localparam int VEC_W       = LAP_W + 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       count_in;
    logic [2:0]       pos;
    logic             pos_valid;
    logic [LAP_W-1:0] lap_count;
    logic             lap_tick;
    logic             err;
    logic [7:0]       err_count;
    logic [1:0]       state;

    shift_pattern_monitor #(
        .LAP_W       (LAP_W),
        .RESYNC_HITS (RESYNC_HITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .pos       (pos),
        .pos_valid (pos_valid),
        .lap_count (lap_count),
        .lap_tick  (lap_tick),
        .err       (err),
        .err_count (err_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (mode: 0 hunting, 1 tracking, 2 fault)
    int m_prev  = 0;
    int m_mode  = 0;
    int m_hits  = 0;
    int m_pos   = 0;
    int m_valid = 0;
    int m_laps  = 0;
    int m_tick  = 0;
    int m_err   = 0;
    int m_errs  = 0;

    logic [7:0] cur = 8'h00;

    wire [VEC_W-1:0] act_vec = {state, pos, pos_valid, lap_count, lap_tick, err, err_count};

    function automatic int rotl(int x);
        return ((x << 1) | (x >> 7)) & 255;
    endfunction

    function automatic bit onehot(int x);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            if (((x >> i) & 1) == 1) c++;
        end
        return c == 1;
    endfunction

    function automatic int bit_index(int x);
        int idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (x == (1 << i)) idx = i;
        end
        return idx;
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec();
        return {2'(m_mode), 3'(m_pos), 1'(m_valid), LAP_W'(m_laps),
                1'(m_tick), 1'(m_err), 8'(m_errs)};
    endfunction

    // Apply the bus value for one clock, advance the model, sample after the edge.
    task automatic cyc(input logic [7:0] v, input bit r);
        bit st;
        bit hd;
        int vi;
        count_in = v;
        reset    = r;
        @(posedge clk);
        vi = int'(v);
        if (r) begin
            m_prev = 0; m_mode = 0; m_hits = 0; m_pos = 0; m_valid = 0;
            m_laps = 0; m_tick = 0; m_err = 0; m_errs = 0;
        end else begin
            st = onehot(m_prev) && (vi == rotl(m_prev));
            hd = onehot(m_prev) && (vi == m_prev);
            m_tick = 0;
            if (m_mode == 0) begin
                if (st) begin
                    m_hits++;
                    if (m_hits == RESYNC_HITS) begin
                        m_mode = 1; m_pos = bit_index(vi); m_valid = 1; m_hits = 0;
                    end
                end else begin
                    m_hits = 0;
                end
            end else if (m_mode == 1) begin
                if (st) begin
                    m_pos = bit_index(vi);
                    if (m_prev == 128 && vi == 1) begin
                        m_laps = (m_laps + 1) % (1 << LAP_W);
                        m_tick = 1;
                    end
                end else if (!hd) begin
                    m_mode = 2; m_valid = 0; m_err = 1;
                    if (m_errs < 255) m_errs++;
                end
            end else begin
                m_mode = 0; m_hits = 0;
            end
            m_prev = vi;
        end
        #1;
        cur = v;
    endtask

    task automatic test_reset();
        repeat (3) cyc(8'h01, 1'b1);
        n_checks++;
        if (act_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", act_vec, {VEC_W{1'b0}});
        end
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_lock();
        cyc(8'h01, 1'b0);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_first_edge_state: got %0d expected 0", state);
        end
        cyc(8'h02, 1'b0);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_one_hit_state: got %0d expected 0", state);
        end
        cyc(8'h04, 1'b0);
        n_checks++;
        if (state !== 2'd1 || pos_valid !== 1'b1 || pos !== 3'd2) begin
            n_fail++;
            $display("FAIL lock_entry: got state=%0d valid=%0d pos=%0d expected 1/1/2",
                     state, pos_valid, pos);
        end
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL lock_model: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_laps();
        int ticks[$];
        for (int i = 0; i < 24; i++) begin
            cyc(8'(rotl(int'(cur))), 1'b0);
            if (lap_tick === 1'b1) ticks.push_back(i);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL laps_model cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        n_checks++;
        if (ticks.size() != 3) begin
            n_fail++;
            $display("FAIL laps_tick_count: got %0d expected 3", ticks.size());
        end else begin
            n_checks++;
            if (ticks[1] - ticks[0] != 8 || ticks[2] - ticks[1] != 8) begin
                n_fail++;
                $display("FAIL laps_tick_spacing: got %0d,%0d expected 8,8",
                         ticks[1] - ticks[0], ticks[2] - ticks[1]);
            end
        end
        n_checks++;
        if (lap_count !== LAP_W'(3) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL laps_total: got laps=%0d err=%0d expected 3/0", lap_count, err);
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        while (cur != 8'h10 && guard < 8) begin
            cyc(8'(rotl(int'(cur))), 1'b0);
            guard++;
        end
        n_checks++;
        if (cur != 8'h10) begin
            n_fail++;
            $display("FAIL stall_reach: got %h expected 10", cur);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(8'h10, 1'b0);
            n_checks++;
            if (pos !== 3'd4 || state !== 2'd1 || err !== 1'b0 || lap_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got pos=%0d state=%0d err=%0d tick=%0d expected 4/1/0/0",
                         i, pos, state, err, lap_tick);
            end
        end
        cyc(8'h20, 1'b0);
        n_checks++;
        if (pos !== 3'd5 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_resume: got pos=%0d state=%0d expected 5/1", pos, state);
        end
    endtask

    task automatic test_fault_relock();
        int guard = 0;
        int laps_before;
        while (cur != 8'h08 && guard < 8) begin
            cyc(8'(rotl(int'(cur))), 1'b0);
            guard++;
        end
        laps_before = m_laps;
        cyc(8'h20, 1'b0);
        n_checks++;
        if (state !== 2'd2 || err !== 1'b1 || err_count !== 8'd1 || pos_valid !== 1'b0 || pos !== 3'd3) begin
            n_fail++;
            $display("FAIL fault_skip: got state=%0d err=%0d cnt=%0d valid=%0d pos=%0d expected 2/1/1/0/3",
                     state, err, err_count, pos_valid, pos);
        end
        cyc(8'h40, 1'b0);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL fault_one_cycle: got state=%0d expected 0", state);
        end
        cyc(8'h80, 1'b0);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL fault_hunt: got state=%0d expected 0", state);
        end
        cyc(8'h01, 1'b0);
        n_checks++;
        if (state !== 2'd1 || lap_count !== LAP_W'(laps_before) || err !== 1'b1 || lap_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_relock: got state=%0d laps=%0d err=%0d tick=%0d expected 1/%0d/1/0",
                     state, lap_count, err, lap_tick, laps_before);
        end
    endtask

    task automatic test_non_onehot_saturation();
        int p;
        int bad;
        cyc(8'h02, 1'b0);
        cyc(8'h03, 1'b0);
        n_checks++;
        if (state !== 2'd2 || err_count !== 8'd2) begin
            n_fail++;
            $display("FAIL nonhot_fault: got state=%0d cnt=%0d expected 2/2", state, err_count);
        end
        for (int k = 0; k < 260; k++) begin
            p = int'($urandom_range(0, 7));
            cyc(8'(1 << p), 1'b0);
            cyc(8'(rotl(int'(cur))), 1'b0);
            cyc(8'(rotl(int'(cur))), 1'b0);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_relock %0d: got %h expected %h", k, act_vec, exp_vec());
            end
            do begin
                bad = int'($urandom_range(0, 255));
            end while (bad == rotl(int'(cur)) || bad == int'(cur));
            cyc(8'(bad), 1'b0);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_fault %0d: got %h expected %h", k, act_vec, exp_vec());
            end
        end
        n_checks++;
        if (err_count !== 8'd255 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_final: got cnt=%0d err=%0d expected 255/1", err_count, err);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        cyc(8'h01, 1'b1);
        cyc(8'h01, 1'b0);
        cyc(8'h02, 1'b0);
        cyc(8'h04, 1'b0);
        while (m_laps != 5 && guard < 100) begin
            cyc(8'(rotl(int'(cur))), 1'b0);
            guard++;
        end
        n_checks++;
        if (lap_count !== LAP_W'(5) || state !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_setup: got laps=%0d state=%0d expected 5/1", lap_count, state);
        end
        cyc(8'(rotl(int'(cur))), 1'b1);
        n_checks++;
        if (act_vec !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %h expected %h", act_vec, {VEC_W{1'b0}});
        end
        cyc(8'h01, 1'b0);
        cyc(8'h02, 1'b0);
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_hunt: got state=%0d expected 0", state);
        end
        cyc(8'h04, 1'b0);
        n_checks++;
        if (state !== 2'd1 || pos !== 3'd2 || lap_count !== LAP_W'(0)) begin
            n_fail++;
            $display("FAIL midrst_relock: got state=%0d pos=%0d laps=%0d expected 1/2/0",
                     state, pos, lap_count);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      cyc(8'(rotl(int'(cur))), 1'b0);
            else if (r < 85) cyc(cur, 1'b0);
            else if (r < 97) cyc(8'($urandom_range(0, 255)), 1'b0);
            else             cyc(cur, 1'b1);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        count_in = 8'h01;
        test_reset();
        test_lock();
        test_laps();
        test_stall();
        test_fault_relock();
        test_non_onehot_saturation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_pattern_monitor.md
# shift_pattern_monitor

Downstream consumer of the 8-bit shift counter's `count` bus.
- Checks every clock that the bus follows the legal one-hot rotate-left sequence: 0x01 → 0x02 → … → 0x80 → 0x01.
- Decodes the live bit position and counts completed laps.
- Flags illegal transitions with a sticky error and a saturating error counter.
- Sits between the shift counter and display/status logic, on the same clock and reset.

## Interface
- `LAP_W`, default 8: width of the lap counter.
- `RESYNC_HITS`, default 2: number of consecutive legal rotate steps required in HUNT before entering TRACK (1–7).
- `clk`, input, 1: single system clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `count_in`, input, 8: shift counter output.
- `pos`, output, 3: index of the set bit in the last accepted value.
- `pos_valid`, output, 1: high while in TRACK.
- `lap_count`, output, `LAP_W`: completed 0x80→0x01 wraps seen in TRACK.
- `lap_tick`, output, 1: one-cycle pulse per counted lap.
- `err`, output, 1: sticky fault flag.
- `err_count`, output, 8: number of faults, saturating at 255.
- `state`, output, 2: HUNT=0, TRACK=1, FAULT=2.

## Operation
- Internal register `prev[7:0]` takes `count_in` every cycle and is 0x00 after reset.
- **legal(x):** exactly one bit of x set.
- **step:** `legal(prev)` and `count_in == {prev[6:0], prev[7]}`.
- **hold:** `legal(prev)` and `count_in == prev`.
- **HUNT**
  - On step: hit counter +1.
  - On any other value (including hold): hit counter cleared to 0.
  - When the hit counter reaches `RESYNC_HITS`: go to TRACK on that edge, load `pos` from `count_in`, set `pos_valid`=1, clear hits.
- **TRACK**
  - On step: update `pos`. If `prev`==0x80 and `count_in`==0x01, then `lap_count`+1 (wraps modulo 2^LAP_W) and `lap_tick`=1.
  - On hold: no change and no error. The upstream counter may stall.
  - On anything else (non-one-hot, skipped position, reverse step): go to FAULT, set `err`=1, `err_count`+1 saturating at 255, `pos_valid`=0. `pos` holds its last value.
- **FAULT**
  - Lasts exactly one cycle, then HUNT with hits cleared.
  - The value present during FAULT is still captured into `prev`, so it can serve as the first half of the next step.
- Illegal values in HUNT do not raise `err`. Faults are counted only out of TRACK.
- `err` clears only on `reset`.

## Timing
- All outputs are registered. A value on `count_in` at rising edge N is reflected in `pos`, `pos_valid`, `lap_tick`, `err` and `state` immediately after edge N, i.e. one cycle of latency.
- Reset values: `prev`=0x00, `state`=HUNT, `pos`=0, `pos_valid`=0, `lap_count`=0, `lap_tick`=0, `err`=0, `err_count`=0, hits=0.
- Reset asserted mid-operation: every register returns to its reset value at the next rising edge, overriding any step or fault on that edge. `count_in` is ignored while `reset`=1, and `prev` is forced to 0x00.
- First edge after reset release: `prev`=0x00, so no step is possible. The earliest TRACK entry is `RESYNC_HITS`+1 edges after release.
- A lap that completes on the HUNT→TRACK entry edge is not counted.
- `lap_tick` is never high for two consecutive cycles. With a free-running counter, its minimum spacing is 8 cycles.
- `err_count` at 255 stays at 255. `err` stays 1.

## Test plan
- **Reset then count:** upstream holds 0x01 during reset, then free-runs. Expect `state`=TRACK and `pos_valid`=1 right after the edge that samples 0x04 (`RESYNC_HITS`=2), with `pos`=2.
- **Lap counting:** free-run for 3 full laps after lock. Expect `lap_count`=3, `lap_tick` pulsed 3 times 8 cycles apart, `err`=0.
- **Stall:** in TRACK, hold `count_in`=0x10 for 5 cycles, then continue. Expect `pos`=4 throughout, no `err`, no state change.
- **Fault and relock:** in TRACK at 0x08, drive 0x20 (skip). Expect FAULT for one cycle, `err`=1, `err_count`=1, `pos_valid`=0, then HUNT. Resume at 0x40, 0x80, 0x01: expect TRACK after 0x01, `lap_count` unchanged, `err` still 1.
- **Non-one-hot values and saturation:** drive 0x03 in TRACK and confirm a fault. Force 260 faults. Expect `err_count`=255.
- **Mid-run reset:** assert `reset` for one cycle while in TRACK with `lap_count`=5. Expect all outputs at reset values after that edge, then normal relock.
